// File: rtl/ps2_scan_display_if.sv
// ps2_scan_display_if: pin-side and display-side signals of the PS/2 scan display.
// Ports: ps2_clk/data (raw pins into the receiver), key_valid/key_code/key_break/key_ext
//        (decoded key event), frame_err (error pulse), segs (7 bits per digit, {g..a}).
// slave modport = receiver side, master modport = pin driver / display consumer side.
interface ps2_scan_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    ps2_clk;
    logic                    data;
    logic                    key_valid;
    logic [7:0]              key_code;
    logic                    key_break;
    logic                    key_ext;
    logic                    frame_err;
    logic [7*NUM_DIGITS-1:0] segs;

    modport slave (
        input  ps2_clk,
        input  data,
        output key_valid,
        output key_code,
        output key_break,
        output key_ext,
        output frame_err,
        output segs
    );

    modport master (
        output ps2_clk,
        output data,
        input  key_valid,
        input  key_code,
        input  key_break,
        input  key_ext,
        input  frame_err,
        input  segs
    );
endinterface

// File: rtl/ps2_scan_display.sv
// ps2_scan_display: PS/2 keyboard receiver, E0/F0 prefix decoder and hex history display.
// Ports: clk, rst (sync, active-high); ps2_if (slave modport) carries the raw PS/2 pins in
//        and key_valid/key_code/key_break/key_ext/frame_err/segs out.
// Option: define PS2_PARITY_CHECK_EN to reject frames with a bad odd-parity bit.
module ps2_scan_display #(
    parameter int NUM_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    ps2_scan_display_if.slave   ps2_if
);

    localparam int NSLOT = NUM_DIGITS / 2;
    localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    // XOR mask applied to every digit; also the value of an unlit digit.
    localparam logic [6:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers and falling-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic                   ps2c_s;
    logic                   bit_s;
    logic                   fall;

    // Synchronisers reset to 1 (bus idle level) so reset release never looks like a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_if.ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_if.data};
            clk_prev_q <= ps2c_s;
        end
    end

    assign ps2c_s = clk_sync_q[SYNC_STAGES-1];
    assign bit_s  = dat_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q & ~ps2c_s;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [2:0]      cnt_q;
    logic [7:0]      shift_q;
    logic [WD_W-1:0] wd_q;
    logic            timeout;
    logic            frame_good;
    logic            byte_stb_d, byte_stb_q;
    logic            frame_err_d, frame_err_q;
`ifdef PS2_PARITY_CHECK_EN
    logic            par_q;
`endif

    // A fall in the same cycle restarts the watchdog, so it wins over a timeout.
    assign timeout = (state_q != S_IDLE) && !fall && (wd_q == WD_LAST);

`ifdef PS2_PARITY_CHECK_EN
    assign frame_good = bit_s && ((^shift_q) ^ par_q);
`else
    assign frame_good = bit_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = S_IDLE;
        end else if (fall) begin
            case (state_q)
                S_IDLE:   if (!bit_s) state_d = S_DATA;
                S_DATA:   if (cnt_q == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        byte_stb_d  = 1'b0;
        frame_err_d = 1'b0;
        if (timeout) begin
            frame_err_d = 1'b1;
        end else if (fall && (state_q == S_STOP)) begin
            byte_stb_d  = frame_good;
            frame_err_d = !frame_good;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 3'd0;
            shift_q     <= 8'h00;
            wd_q        <= '0;
            byte_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q       <= 1'b0;
`endif
        end else begin
            byte_stb_q  <= byte_stb_d;
            frame_err_q <= frame_err_d;

            if (fall) begin
                wd_q <= '0;
            end else if (state_q != S_IDLE && !timeout) begin
                wd_q <= wd_q + WD_W'(1);
            end

            if (fall) begin
                case (state_q)
                    S_IDLE: cnt_q <= 3'd0;
                    S_DATA: begin
                        shift_q <= {bit_s, shift_q[7:1]};
                        cnt_q   <= cnt_q + 3'd1;
                    end
`ifdef PS2_PARITY_CHECK_EN
                    S_PARITY: par_q <= bit_s;
`endif
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefix decode and key event outputs
    // shift_q is stable while byte_stb_q is high (no fall can follow the stop bit that fast).
    // ------------------------------------------------------------------
    logic       ext_pend_q, brk_pend_q;
    logic       key_valid_q, key_break_q, key_ext_q;
    logic [7:0] key_code_q;
    logic       is_prefix;
    logic       make_evt;

    assign is_prefix = (shift_q == 8'hE0) || (shift_q == 8'hF0);
    assign make_evt  = byte_stb_q && !is_prefix && !brk_pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= 8'h00;
            key_break_q <= 1'b0;
            key_ext_q   <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (frame_err_q) begin
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end else if (byte_stb_q) begin
                if (shift_q == 8'hE0) begin
                    ext_pend_q <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_pend_q <= 1'b1;
                end else begin
                    key_valid_q <= 1'b1;
                    key_code_q  <= shift_q;
                    key_ext_q   <= ext_pend_q;
                    key_break_q <= brk_pend_q;
                    ext_pend_q  <= 1'b0;
                    brk_pend_q  <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Make-code history: updates on the same edge that raises key_valid.
    // ------------------------------------------------------------------
    logic [7:0]       hist_code_q [NSLOT];
    logic [NSLOT-1:0] hist_vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_vld_q <= '0;
            for (int k = 0; k < NSLOT; k++) begin
                hist_code_q[k] <= 8'h00;
            end
        end else if (make_evt) begin
            hist_code_q[0] <= shift_q;
            hist_vld_q[0]  <= 1'b1;
            for (int k = NSLOT - 1; k > 0; k--) begin
                hist_code_q[k] <= hist_code_q[k-1];
                hist_vld_q[k]  <= hist_vld_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Seven-segment rendering (registered, one cycle behind the history)
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    logic [7*NUM_DIGITS-1:0] segs_d, segs_q;

    always_comb begin
        segs_d = {NUM_DIGITS{SEG_INV}};
        for (int k = 0; k < NSLOT; k++) begin
            if (hist_vld_q[k]) begin
                segs_d[14*k +: 7]     = hex7(hist_code_q[k][3:0]) ^ SEG_INV;
                segs_d[14*k + 7 +: 7] = hex7(hist_code_q[k][7:4]) ^ SEG_INV;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            segs_q <= {NUM_DIGITS{SEG_INV}};
        end else begin
            segs_q <= segs_d;
        end
    end

    assign ps2_if.key_valid = key_valid_q;
    assign ps2_if.key_code  = key_code_q;
    assign ps2_if.key_break = key_break_q;
    assign ps2_if.key_ext   = key_ext_q;
    assign ps2_if.frame_err = frame_err_q;
    assign ps2_if.segs      = segs_q;

endmodule
